// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the decoder-facing valid/ready output.
interface fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // fetch stage side
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );

  // memory / decoder / redirect source side
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues in-order word fetches
// under a credit limit, buffers {pc, instr} in a FIFO for the decoder and
// discards in-flight fetches on redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 3
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [31:0]                  fetch_pc, resp_pc;
  logic [CNT_W-1:0]             count, inflight, drop;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0][31:0]       fifo_pc, fifo_instr;

  logic [CNT_W:0] occupancy;
  logic [31:0]    redirect_base;
  logic           redir, req_fire, resp_fire, push, pop, non_empty;

  // Outstanding fetches still destined for the FIFO count against its space;
  // fetches marked for dropping do not.
  assign occupancy     = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
  assign redir         = bus.redirect_valid;
  assign redirect_base = bus.redirect_pc & 32'hFFFF_FFFC;
  assign non_empty     = (count != '0);

  assign bus.imem_req_valid = !rst && !redir && (occupancy < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = non_empty && !redir;
  assign bus.out_instr      = non_empty ? fifo_instr[rd_ptr] : 32'h0;
  assign bus.out_pc         = non_empty ? fifo_pc[rd_ptr]    : 32'h0;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_fire = bus.imem_resp_valid;
  assign push      = resp_fire && (drop == '0) && !redir;
  assign pop       = bus.out_valid && bus.out_ready;

  // Control state: PCs, occupancy/credit counters and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redir) begin
      // everything still outstanding after this cycle's response is stale
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= inflight - CNT_W'(resp_fire);
      drop     <= inflight - CNT_W'(resp_fire);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp_fire);
      if (resp_fire && (drop != '0)) drop <= drop - 1'b1;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= bus.imem_resp_data;
    end
  end

  // Memory must never return data that was not requested.
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (inflight == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus();
  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { bit out_ready; bit e_req_v; logic [31:0] e_addr; bit e_out_v; logic [31:0] e_pc; } vec_t;

  mreq_t       pend[$];   // requests accepted by memory, oldest first
  ent_t        mq[$];     // what the decoder should see, head first
  logic [31:0] m_fetch;
  logic [31:0] data_xor;
  int          epoch, cyc, lat_min, lat_max;
  int          tests, fails;
  bit          e_req_v, e_out_v;
  vec_t        tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int live();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) n++;
    return n;
  endfunction

  // Drive the memory response for this cycle, then compare outputs to the model.
  task automatic pre();
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = pend[0].addr ^ data_xor;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    #1;
    e_req_v = !bus.redirect_valid && (mq.size() + live() < 4);
    e_out_v = (mq.size() != 0) && !bus.redirect_valid;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(e_req_v));
    if (e_req_v) chk("req_addr", bus.imem_req_addr, m_fetch);
    chk("out_valid", 32'(bus.out_valid), 32'(e_out_v));
    chk("out_pc", bus.out_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
    chk("out_instr", bus.out_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
  endtask

  // Advance the model across the clock edge using this cycle's handshakes.
  task automatic post();
    mreq_t p;
    bit    do_push;
    ent_t  e;
    @(posedge clk);
    do_push = 1'b0;
    if (bus.imem_resp_valid) begin
      p = pend.pop_front();
      if (!bus.redirect_valid && p.epoch == epoch) begin
        do_push = 1'b1;
        e.pc = p.addr;
        e.instr = bus.imem_resp_data;
      end
    end
    if (e_out_v && bus.out_ready) void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    if (e_req_v && bus.imem_req_ready) begin
      pend.push_back('{m_fetch, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      m_fetch = m_fetch + 32'd4;
    end
    if (bus.redirect_valid) begin
      mq.delete();
      m_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
      epoch++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    pre();
    post();
  endtask

  // Reset DUT, memory and model together; outputs must drop at once.
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    pend.delete();
    mq.delete();
    m_fetch = 32'h0;
    epoch++;
    cyc = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit got;
    logic [31:0] held;
    tests = 0; fails = 0; epoch = 0; cyc = 0;
    lat_min = 1; lat_max = 1; data_xor = 32'h0; m_fetch = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
    bus.out_ready = 1'b0;

    // from reset, latency 1, data = address; decoder stalls 5 cycles then drains
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[6]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[7]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[8]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[9]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[10] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.out_ready = tbl[i].out_ready;
      pre();
      chk("tbl_req_valid", 32'(bus.imem_req_valid), 32'(tbl[i].e_req_v));
      if (tbl[i].e_req_v) chk("tbl_req_addr", bus.imem_req_addr, tbl[i].e_addr);
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_out_v));
      if (tbl[i].e_out_v) begin
        chk("tbl_out_pc", bus.out_pc, tbl[i].e_pc);
        chk("tbl_out_instr", bus.out_instr, tbl[i].e_pc);
      end
      post();
    end

    // redirect with three fetches outstanding at latency 3
    lat_min = 3; lat_max = 3; data_xor = 32'h5A5A_0000;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (3) step();
    chk("three_outstanding", 32'(pend.size()), 32'd3);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pre();
      if (bus.out_valid) begin got = 1'b1; break; end
      post();
    end
    chk("redir_data_seen", 32'(got), 32'h1);
    chk("redir_first_pc", bus.out_pc, 32'h100);
    chk("redir_first_instr", bus.out_instr, 32'h100 ^ data_xor);
    bus.out_ready = 1'b1;
    post();
    pre();
    chk("redir_second_pc", bus.out_pc, 32'h104);
    post();

    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() != 0 && pend[0].due <= cyc && mq.size() != 0) begin got = 1'b1; break; end
      step();
    end
    chk("collide_setup", 32'(got), 32'h1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    pre();
    chk("collide_resp", 32'(bus.imem_resp_valid), 32'h1);
    post();
    bus.redirect_valid = 1'b0;
    pre();
    chk("collide_next_addr", bus.imem_req_addr, 32'h200);
    chk("collide_empty", 32'(bus.out_valid), 32'h0);
    post();

    // memory stalls requests for 5 cycles
    do_reset();
    bus.out_ready = 1'b1;
    repeat (3) step();
    bus.imem_req_ready = 1'b0;
    held = m_fetch;
    for (int i = 0; i < 5; i++) begin
      pre();
      chk("stall_valid", 32'(bus.imem_req_valid), 32'h1);
      chk("stall_addr", bus.imem_req_addr, held);
      post();
    end
    bus.imem_req_ready = 1'b1;
    repeat (2) step();
    chk("stall_no_skip", m_fetch, held + 32'd8);

    // reset mid-stream with a full FIFO
    bus.out_ready = 1'b0;
    repeat (8) step();
    chk("full_before_rst", 32'(mq.size()), 32'd4);
    do_reset();
    pre();
    chk("rst_restart_addr", bus.imem_req_addr, 32'h0);
    post();

    // randomized traffic
    lat_min = 1; lat_max = 4; data_xor = $urandom;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.out_ready      = ($urandom_range(2, 0) != 0);
      bus.redirect_valid = ($urandom_range(15, 0) == 0);
      bus.redirect_pc    = $urandom;
      step();
    end
    bus.redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
